lector_teclado_fifo: RTL and testbench

Parametrised keypad scanner, next generation of the single-key latch reader. Drives a one-hot column scan and samples row lines, then debounces both press and release. Each debounced event is encoded as a linear key code with a press/release flag and pushed into an event FIFO. The consumer drains the FIFO with the existing ack_read handshake. It sits between the keypad pins and the input-decoding logic.

---
 rtl/lector_teclado_fifo.sv | 186 ++++++++++++++++++
 tb/tb_lector_teclado_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lector_teclado_fifo.sv
// Keypad scanner: one-hot column scan, press/release debounce, and a
// first-word-fall-through event FIFO drained with an ack_read handshake.
module lector_teclado_fifo #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned DEBOUNCE_PULSES = 3,
  parameter int unsigned SCAN_CYCLES     = 1,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned RELEASE_EVT     = 1,
  localparam int unsigned CODE_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [COLS-1:0]   col,
  input  logic [ROWS-1:0]   fil,
  output logic [CODE_W-1:0] key_code,
  output logic              key_release,
  output logic              key_valid,
  input  logic              ack_read,
  output logic              overflow
);

  localparam int unsigned COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_PULSES + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_t;

  state_t            state, state_nxt;
  logic [COL_W-1:0]  col_idx, col_idx_nxt, col_adv;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
  logic [ROWS-1:0]   pat, pat_nxt;
  logic [ROW_W-1:0]  row_idx, row_idx_nxt, row_now, push_row;
  logic              push, push_rel;
  logic [CODE_W-1:0] push_code;

  logic [CODE_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              pop, full, do_write, drop;

  function automatic logic [ROW_W-1:0] lowest_row(input logic [ROWS-1:0] v);
    lowest_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (v[ROW_W'(i)]) lowest_row = ROW_W'(i);
    end
  endfunction

  assign row_now   = lowest_row(fil);
  assign col_adv   = (col_idx == COL_W'(COLS - 1)) ? '0 : col_idx + 1'b1;
  assign push_code = CODE_W'(32'(push_row) * COLS + 32'(col_idx));

  // Scan / debounce next-state; the column stays frozen while a key is tracked
  always_comb begin
    state_nxt    = state;
    col_idx_nxt  = col_idx;
    scan_cnt_nxt = scan_cnt;
    deb_cnt_nxt  = deb_cnt;
    pat_nxt      = pat;
    row_idx_nxt  = row_idx;
    push         = 1'b0;
    push_rel     = 1'b0;
    push_row     = row_idx;
    unique case (state)
      ST_SCAN: begin
        if (fil == '0) begin
          if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_cnt_nxt = '0;
            col_idx_nxt  = col_adv;
          end else begin
            scan_cnt_nxt = scan_cnt + 1'b1;
          end
        end else begin
          pat_nxt      = fil;
          row_idx_nxt  = row_now;
          scan_cnt_nxt = '0;
          deb_cnt_nxt  = DEB_W'(1);
          if (DEBOUNCE_PULSES == 1) begin
            push        = 1'b1;
            push_row    = row_now;
            deb_cnt_nxt = '0;
            state_nxt   = ST_HELD;
          end else begin
            state_nxt = ST_DEBOUNCE;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (fil == pat) begin
          if (deb_cnt == DEB_W'(DEBOUNCE_PULSES - 1)) begin
            push        = 1'b1;
            deb_cnt_nxt = '0;
            state_nxt   = ST_HELD;
          end else begin
            deb_cnt_nxt = deb_cnt + 1'b1;
          end
        end else begin
          deb_cnt_nxt = '0;
          col_idx_nxt = col_adv;
          state_nxt   = ST_SCAN;
        end
      end
      ST_HELD: begin
        if (fil == '0) begin
          if (deb_cnt == DEB_W'(DEBOUNCE_PULSES - 1)) begin
            push        = (RELEASE_EVT != 0);
            push_rel    = 1'b1;
            deb_cnt_nxt = '0;
            col_idx_nxt = col_adv;
            state_nxt   = ST_SCAN;
          end else begin
            deb_cnt_nxt = deb_cnt + 1'b1;
          end
        end else begin
          deb_cnt_nxt = '0;
        end
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

  // FIFO bookkeeping: pop is applied before push, so a full FIFO accepts push+pop
  always_comb begin
    pop        = ack_read && (count != '0);
    full       = (count == CNT_W'(FIFO_DEPTH));
    do_write   = push && (!full || pop);
    drop       = push && full && !pop;
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    wr_ptr_nxt = do_write ? wr_ptr + 1'b1 : wr_ptr;
    case ({do_write, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && do_write) mem[wr_ptr] <= {push_rel, push_code};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_SCAN;
      col_idx     <= '0;
      col         <= COLS'(1);
      scan_cnt    <= '0;
      deb_cnt     <= '0;
      pat         <= '0;
      row_idx     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_release <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_idx_nxt;
      col       <= COLS'(1) << col_idx_nxt;
      scan_cnt  <= scan_cnt_nxt;
      deb_cnt   <= deb_cnt_nxt;
      pat       <= pat_nxt;
      row_idx   <= row_idx_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      key_valid <= (count_nxt != '0);
      overflow  <= overflow | drop;
      // Head register: bypass the write when the new entry becomes the head
      if (count_nxt != '0) begin
        if (do_write && (rd_ptr_nxt == wr_ptr)) {key_release, key_code} <= {push_rel, push_code};
        else                                    {key_release, key_code} <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: tb/tb_lector_teclado_fifo.sv
// Directed bench for lector_teclado_fifo with immediate-assertion checks.
module tb_lector_teclado_fifo;

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] fil;
  logic [3:0] key_code;
  logic       key_release;
  logic       key_valid;
  logic       ack_read;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  lector_teclado_fifo #(
    .ROWS(4), .COLS(4), .DEBOUNCE_PULSES(3), .SCAN_CYCLES(1),
    .FIFO_DEPTH(4), .RELEASE_EVT(1)
  ) dut (
    .clk(clk), .rst(rst), .col(col), .fil(fil), .key_code(key_code),
    .key_release(key_release), .key_valid(key_valid), .ack_read(ack_read),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] code, input logic [31:0] rel);
    chk({tag, "_valid"}, 32'(key_valid), 32'd1);
    chk({tag, "_code"}, 32'(key_code), code);
    chk({tag, "_rel"}, 32'(key_release), rel);
  endtask

  task automatic wait_col(input logic [3:0] c);
    for (int i = 0; i < 16 && col !== c; i++) tick();
    chk("wait_col", 32'(col), 32'(c));
  endtask

  // Press for 4 samples (press pushed on the 3rd), then release for 3 samples
  task automatic press_key(input logic [3:0] c, input logic [3:0] f);
    wait_col(c);
    fil = f;
    repeat (4) tick();
    fil = 4'b0000;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fil = 4'b0000; ack_read = 1'b0;

    // Reset state and free-running column scan
    do_reset();
    chk("rst_col", 32'(col), 32'b0001);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_rel", 32'(key_release), 32'd0);
    tick(); chk("scan1", 32'(col), 32'b0010);
    tick(); chk("scan2", 32'(col), 32'b0100);
    tick(); chk("scan3", 32'(col), 32'b1000);
    tick(); chk("scan_wrap", 32'(col), 32'b0001);
    chk("scan_valid", 32'(key_valid), 32'd0);

    // Press row1 at col2 -> code 6, then release
    wait_col(4'b0100);
    fil = 4'b0010;
    tick(); chk("lat1_valid", 32'(key_valid), 32'd0);
    chk("frozen_col", 32'(col), 32'b0100);
    tick(); chk("lat2_valid", 32'(key_valid), 32'd0);
    tick(); chk_head("press6", 32'd6, 32'd0);
    repeat (7) tick();
    chk("held_col", 32'(col), 32'b0100);
    chk_head("held6", 32'd6, 32'd0);
    fil = 4'b0000;
    tick(); tick();
    chk("rel_pending_col", 32'(col), 32'b0100);
    tick(); chk("resume_col", 32'(col), 32'b1000);
    ack_read = 1'b1;
    tick(); chk_head("release6", 32'd6, 32'd1);
    tick(); chk("drained", 32'(key_valid), 32'd0);
    ack_read = 1'b0;

    // Glitch shorter than the debounce window is rejected
    wait_col(4'b0001);
    fil = 4'b0100;
    tick(); tick();
    fil = 4'b0000;
    tick();
    chk("glitch_valid", 32'(key_valid), 32'd0);
    chk("glitch_col", 32'(col), 32'b0010);

    // Release bounce yields exactly one release event
    wait_col(4'b0001);
    fil = 4'b0001;
    repeat (3) tick();
    chk_head("press0", 32'd0, 32'd0);
    ack_read = 1'b1;
    tick();
    ack_read = 1'b0;
    chk("press0_popped", 32'(key_valid), 32'd0);
    fil = 4'b0000; tick(); tick();
    fil = 4'b0001; tick();
    fil = 4'b0000; tick(); tick();
    chk("bounce_no_rel", 32'(key_valid), 32'd0);
    tick();
    chk_head("release0", 32'd0, 32'd1);
    ack_read = 1'b1;
    tick();
    ack_read = 1'b0;
    chk("bounce_single", 32'(key_valid), 32'd0);

    // Overflow: 6 events into a 4-deep FIFO; two rows in col3 encode as row1
    press_key(4'b0010, 4'b0001);
    press_key(4'b1000, 4'b1010);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    press_key(4'b0001, 4'b0100);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk_head("ovf_head", 32'd1, 32'd0);
    ack_read = 1'b1;
    tick(); chk_head("ovf_pop1", 32'd1, 32'd1);
    tick(); chk_head("ovf_pop2", 32'd7, 32'd0);
    tick(); chk_head("ovf_pop3", 32'd7, 32'd1);
    tick(); chk("ovf_empty", 32'(key_valid), 32'd0);
    ack_read = 1'b0;
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Push and pop on the same edge while full
    do_reset();
    chk("rst2_ovf", 32'(overflow), 32'd0);
    press_key(4'b0001, 4'b0001);
    press_key(4'b0100, 4'b0001);
    chk_head("full_head", 32'd0, 32'd0);
    wait_col(4'b0010);
    fil = 4'b1000;
    tick(); tick();
    ack_read = 1'b1;
    tick();
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk_head("pp_head", 32'd0, 32'd1);
    tick();
    ack_read = 1'b0;
    chk_head("pp_head2", 32'd2, 32'd0);
    fil = 4'b0000;
    repeat (3) tick();
    chk("pp_ovf2", 32'(overflow), 32'd0);
    ack_read = 1'b1;
    tick(); chk_head("pp_pop1", 32'd2, 32'd1);
    tick(); chk_head("pp_tail", 32'd13, 32'd0);
    tick(); chk_head("pp_pop3", 32'd13, 32'd1);
    tick(); chk("pp_empty", 32'(key_valid), 32'd0);
    ack_read = 1'b0;

    // Reset while HELD with two entries queued
    press_key(4'b0100, 4'b0100);
    ack_read = 1'b1;
    tick();
    ack_read = 1'b0;
    wait_col(4'b0001);
    fil = 4'b0010;
    repeat (4) tick();
    chk_head("mid_head", 32'd10, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_col", 32'(col), 32'b0001);
    chk("mid_valid", 32'(key_valid), 32'd0);
    chk("mid_ovf", 32'(overflow), 32'd0);
    tick(); chk("redet1", 32'(key_valid), 32'd0);
    tick(); chk("redet2", 32'(key_valid), 32'd0);
    tick(); chk_head("redetect", 32'd4, 32'd0);
    fil = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
